// File: rtl/sonar_sequenciador.sv
`default_nettype none
// =============================================================================
// sonar_sequenciador : sweep controller that positions the servo, measures and transmits
// Rev 1.0
// =============================================================================
module sonar_sequenciador #(
  parameter int SETTLE_CYCLES  = 25000000,
  parameter int TIMEOUT_CYCLES = 3000000,
  parameter int N_CHARS        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       sensor_pronto,
  input  logic       serial_pronto,
  output logic       medicao,
  output logic       transmissao,
  output logic [2:0] sel_posicao,
  output logic [2:0] sel_rom,
  output logic [2:0] sel_transmissao,
  output logic       erro_medida,
  output logic       fim_posicao,
  output logic [3:0] db_estado
);

  localparam int MAX_WAIT = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TIMER_W  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]         LAST_CHAR    = 3'(N_CHARS - 1);
  localparam logic [2:0]         POS_MAX      = 3'd7;
  localparam logic [2:0]         POS_MIN      = 3'd0;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    ESPERA_SERVO   = 4'd1,
    MEDE           = 4'd2,
    AGUARDA_MEDIDA = 4'd3,
    TRANSMITE      = 4'd4,
    AGUARDA_SERIAL = 4'd5,
    PROXIMO_CHAR   = 4'd6,
    FIM_POSICAO    = 4'd7,
    MOVE           = 4'd8
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TIMER_W-1:0]   timer_inc;
  logic [2:0]           sel_posicao_q, sel_posicao_d;
  logic [2:0]           sel_transmissao_q, sel_transmissao_d;
  logic                 dir_down_q, dir_down_d;
  logic                 erro_medida_q, erro_medida_d;
  logic                 medicao_q, medicao_d;
  logic                 transmissao_q, transmissao_d;
  logic                 fim_posicao_q, fim_posicao_d;

  // Saturating increment: the timer holds at all-ones instead of wrapping.
  assign timer_inc = (timer_q == {TIMER_W{1'b1}}) ? timer_q : timer_q + TIMER_W'(1);

  always_comb begin
    state_d           = state_q;
    timer_d           = '0;
    sel_posicao_d     = sel_posicao_q;
    sel_transmissao_d = sel_transmissao_q;
    dir_down_d        = dir_down_q;
    erro_medida_d     = erro_medida_q;

    case (state_q)
      INICIAL: begin
        if (ligar) begin
          state_d = ESPERA_SERVO;
        end
      end

      ESPERA_SERVO: begin
        if (timer_q == SETTLE_LAST) begin
          state_d = MEDE;
        end else begin
          timer_d = timer_inc;
        end
      end

      MEDE: begin
        sel_transmissao_d = '0;
        state_d           = AGUARDA_MEDIDA;
      end

      AGUARDA_MEDIDA: begin
        // A completed measurement takes priority over a coincident timeout.
        if (sensor_pronto) begin
          erro_medida_d = 1'b0;
          state_d       = TRANSMITE;
        end else if (timer_q == TIMEOUT_LAST) begin
          erro_medida_d = 1'b1;
          state_d       = TRANSMITE;
        end else begin
          timer_d = timer_inc;
        end
      end

      TRANSMITE: begin
        state_d = AGUARDA_SERIAL;
      end

      AGUARDA_SERIAL: begin
        if (serial_pronto) begin
          state_d = PROXIMO_CHAR;
        end
      end

      PROXIMO_CHAR: begin
        if (sel_transmissao_q == LAST_CHAR) begin
          state_d = FIM_POSICAO;
        end else begin
          sel_transmissao_d = sel_transmissao_q + 3'd1;
          state_d           = TRANSMITE;
        end
      end

      FIM_POSICAO: begin
        state_d = MOVE;
      end

      MOVE: begin
        // Endpoints bounce directly to their neighbour so each is visited once per turn.
        if (!dir_down_q) begin
          if (sel_posicao_q == POS_MAX) begin
            dir_down_d    = 1'b1;
            sel_posicao_d = POS_MAX - 3'd1;
          end else begin
            sel_posicao_d = sel_posicao_q + 3'd1;
          end
        end else begin
          if (sel_posicao_q == POS_MIN) begin
            dir_down_d    = 1'b0;
            sel_posicao_d = POS_MIN + 3'd1;
          end else begin
            sel_posicao_d = sel_posicao_q - 3'd1;
          end
        end
        state_d = ligar ? ESPERA_SERVO : INICIAL;
      end

      default: begin
        state_d = INICIAL;
      end
    endcase

    medicao_d     = (state_d == MEDE);
    transmissao_d = (state_d == TRANSMITE);
    fim_posicao_d = (state_d == FIM_POSICAO);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= INICIAL;
      timer_q           <= '0;
      sel_posicao_q     <= '0;
      sel_transmissao_q <= '0;
      dir_down_q        <= 1'b0;
      erro_medida_q     <= 1'b0;
      medicao_q         <= 1'b0;
      transmissao_q     <= 1'b0;
      fim_posicao_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      sel_posicao_q     <= sel_posicao_d;
      sel_transmissao_q <= sel_transmissao_d;
      dir_down_q        <= dir_down_d;
      erro_medida_q     <= erro_medida_d;
      medicao_q         <= medicao_d;
      transmissao_q     <= transmissao_d;
      fim_posicao_q     <= fim_posicao_d;
    end
  end

  assign medicao         = medicao_q;
  assign transmissao     = transmissao_q;
  assign sel_posicao     = sel_posicao_q;
  assign sel_rom         = sel_posicao_q;
  assign sel_transmissao = sel_transmissao_q;
  assign erro_medida     = erro_medida_q;
  assign fim_posicao     = fim_posicao_q;
  assign db_estado       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sonar_sequenciador.sv
`default_nettype none
// =============================================================================
// tb_sonar_sequenciador : randomized sweep positions checked against a timing model
// Rev 1.0
// =============================================================================
module tb_sonar_sequenciador;

  localparam int SETTLE = 4;
  localparam int TO     = 20;
  localparam int NCH    = 8;
  localparam int BUDGET = 400;

  logic       clock = 1'b0;
  logic       reset;
  logic       ligar;
  logic       sensor_pronto;
  logic       serial_pronto;
  logic       medicao;
  logic       transmissao;
  logic [2:0] sel_posicao;
  logic [2:0] sel_rom;
  logic [2:0] sel_transmissao;
  logic       erro_medida;
  logic       fim_posicao;
  logic [3:0] db_estado;

  sonar_sequenciador #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TO),
    .N_CHARS       (NCH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ligar          (ligar),
    .sensor_pronto  (sensor_pronto),
    .serial_pronto  (serial_pronto),
    .medicao        (medicao),
    .transmissao    (transmissao),
    .sel_posicao    (sel_posicao),
    .sel_rom        (sel_rom),
    .sel_transmissao(sel_transmissao),
    .erro_medida    (erro_medida),
    .fim_posicao    (fim_posicao),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  int checks  = 0;
  int errors  = 0;
  int k_sweep = 0;

  typedef struct packed {
    int          pos;
    int          es_to_med;
    int          med_to_tx;
    int          n_tx;
    int          n_fim;
    int          rom_bad;
    int          stab_bad;
    int          pos_bad;
    int          pos_after;
    int          state_after;
    int          total;
    int          rst_pos;
    int          rst_st;
    logic        erro;
    logic        timed_out;
    logic        rst_hit;
    logic        rst_tx;
    logic [63:0] tx_seq;
  } obs_t;

  // Triangle sweep: index k of the continuous sweep -> servo position.
  function automatic int tri_pos(input int k);
    int m;
    m = k % 14;
    return (m < 8) ? m : 14 - m;
  endfunction

  function automatic int exp_med_to_tx(input int d);
    return (d >= 1 && d <= TO) ? d + 1 : TO + 1;
  endfunction

  function automatic logic exp_erro(input int d);
    return !(d >= 1 && d <= TO);
  endfunction

  function automatic logic [63:0] exp_seq();
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < NCH; i++) s = {s[59:0], 4'(i)};
    return s;
  endfunction

  // Position length from settle entry to the next settle entry.
  function automatic int exp_total(input int d, input int ks);
    return SETTLE + exp_med_to_tx(d) + NCH * (ks + 2) + 2;
  endfunction

  // Drives one position from its first settle cycle and records what happened.
  task automatic run_position(input int sens_d, input int ser_k, input int drop_char,
                              input int rst_char, output obs_t o);
    int         t_med, t_fim, sens_at, ser_at, drop_at;
    logic [2:0] cur_tx;
    o = '0;
    t_med = -1; t_fim = -1; sens_at = -1; ser_at = -1; drop_at = -1; cur_tx = '0;
    o.pos       = int'(sel_posicao);
    o.timed_out = 1'b1;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      if (t_fim >= 0 && cyc > t_fim && (db_estado == 4'd1 || db_estado == 4'd0)) begin
        o.pos_after   = int'(sel_posicao);
        o.state_after = int'(db_estado);
        o.total       = cyc;
        o.timed_out   = 1'b0;
        break;
      end
      if (sel_rom !== sel_posicao) o.rom_bad = o.rom_bad + 1;
      if (sel_posicao !== 3'(o.pos)) o.pos_bad = o.pos_bad + 1;
      if (medicao === 1'b1) begin
        t_med       = cyc;
        o.es_to_med = cyc;
        if (sens_d > 0) sens_at = cyc + sens_d;
      end
      if (transmissao === 1'b1) begin
        if (o.n_tx == 0) begin
          o.med_to_tx = cyc - t_med;
          o.erro      = erro_medida;
        end
        if (o.n_tx < 16) o.tx_seq = {o.tx_seq[59:0], 1'b0, sel_transmissao};
        cur_tx = sel_transmissao;
        ser_at = cyc + ser_k;
        if (o.n_tx == drop_char) drop_at = cyc + 1;
        if (o.n_tx == rst_char) begin
          reset = 1'b1; sensor_pronto = 1'b0; serial_pronto = 1'b0;
          #1;
          o.rst_hit   = 1'b1;
          o.rst_tx    = transmissao;
          o.rst_pos   = int'(sel_posicao);
          o.rst_st    = int'(db_estado);
          o.timed_out = 1'b0;
          break;
        end
        o.n_tx = o.n_tx + 1;
      end
      if (db_estado == 4'd5 && sel_transmissao !== cur_tx) o.stab_bad = o.stab_bad + 1;
      if (fim_posicao === 1'b1) begin
        o.n_fim = o.n_fim + 1;
        t_fim   = cyc;
      end
      sensor_pronto = (cyc == sens_at);
      serial_pronto = (cyc == ser_at);
      if (cyc == drop_at) ligar = 1'b0;
      @(negedge clock);
    end
    sensor_pronto = 1'b0;
    serial_pronto = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] st, input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (db_estado == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_fresh(output logic ok);
    @(negedge clock);
    reset = 1'b1; ligar = 1'b0; sensor_pronto = 1'b0; serial_pronto = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    k_sweep = 0;
    @(negedge clock);
    ligar = 1'b1;
    wait_state(4'd1, 5, ok);
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; ligar = 1'b0; sensor_pronto = 1'b0; serial_pronto = 1'b0;
    @(negedge clock);
    checks++; if (medicao !== 1'b0) begin errors++; $display("FAIL reset_medicao: got %b expected 0", medicao); end
    checks++; if (transmissao !== 1'b0) begin errors++; $display("FAIL reset_transmissao: got %b expected 0", transmissao); end
    checks++; if (fim_posicao !== 1'b0) begin errors++; $display("FAIL reset_fim: got %b expected 0", fim_posicao); end
    checks++; if (erro_medida !== 1'b0) begin errors++; $display("FAIL reset_erro: got %b expected 0", erro_medida); end
    checks++; if (sel_posicao !== 3'd0) begin errors++; $display("FAIL reset_pos: got %0d expected 0", sel_posicao); end
    checks++; if (sel_rom !== 3'd0) begin errors++; $display("FAIL reset_rom: got %0d expected 0", sel_rom); end
    checks++; if (sel_transmissao !== 3'd0) begin errors++; $display("FAIL reset_seltx: got %0d expected 0", sel_transmissao); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", db_estado); end
    reset = 1'b0;
    k_sweep = 0;
    repeat (3) @(negedge clock);
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL idle_without_ligar: got %0d expected 0", db_estado); end
  endtask

  task automatic test_first_position();
    obs_t o;
    logic ok;
    ligar = 1'b1;
    wait_state(4'd1, 5, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL first_enter_settle: got %b expected 1", ok); end
    run_position(3, 2, -1, -1, o);
    checks++; if (o.timed_out !== 1'b0) begin errors++; $display("FAIL first_budget: got %b expected 0", o.timed_out); end
    checks++; if (o.es_to_med != SETTLE) begin errors++; $display("FAIL first_settle: got %0d expected %0d", o.es_to_med, SETTLE); end
    checks++; if (o.med_to_tx != 4) begin errors++; $display("FAIL first_med_to_tx: got %0d expected 4", o.med_to_tx); end
    checks++; if (o.n_tx != NCH) begin errors++; $display("FAIL first_ntx: got %0d expected %0d", o.n_tx, NCH); end
    checks++; if (o.tx_seq !== exp_seq()) begin errors++; $display("FAIL first_txseq: got %h expected %h", o.tx_seq, exp_seq()); end
    checks++; if (o.n_fim != 1) begin errors++; $display("FAIL first_fim: got %0d expected 1", o.n_fim); end
    checks++; if (o.pos_after != 1) begin errors++; $display("FAIL first_pos_after: got %0d expected 1", o.pos_after); end
    checks++; if (o.erro !== 1'b0) begin errors++; $display("FAIL first_erro: got %b expected 0", o.erro); end
    checks++; if (o.total != exp_total(3, 2)) begin errors++; $display("FAIL first_total: got %0d expected %0d", o.total, exp_total(3, 2)); end
    k_sweep++;
  endtask

  task automatic test_sweep();
    obs_t o;
    logic ok;
    int   d, ks;
    start_fresh(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sweep_start: got %b expected 1", ok); end
    for (int i = 0; i < 16; i++) begin
      d  = $urandom_range(1, TO);
      ks = $urandom_range(1, 4);
      run_position(d, ks, -1, -1, o);
      checks++; if (o.timed_out !== 1'b0) begin errors++; $display("FAIL sweep_budget[%0d]: got %b expected 0", i, o.timed_out); end
      checks++; if (o.pos != tri_pos(k_sweep)) begin errors++; $display("FAIL sweep_pos[%0d]: got %0d expected %0d", i, o.pos, tri_pos(k_sweep)); end
      checks++; if (o.rom_bad != 0 || o.pos_bad != 0) begin errors++; $display("FAIL sweep_rom_stable[%0d]: got %0d/%0d expected 0/0", i, o.rom_bad, o.pos_bad); end
      checks++; if (o.pos_after != tri_pos(k_sweep + 1)) begin errors++; $display("FAIL sweep_pos_after[%0d]: got %0d expected %0d", i, o.pos_after, tri_pos(k_sweep + 1)); end
      checks++; if (o.total != exp_total(d, ks)) begin errors++; $display("FAIL sweep_total[%0d]: got %0d expected %0d", i, o.total, exp_total(d, ks)); end
      k_sweep++;
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    int   d;
    run_position(0, $urandom_range(1, 4), -1, -1, o);
    checks++; if (o.erro !== 1'b1) begin errors++; $display("FAIL timeout_erro: got %b expected 1", o.erro); end
    checks++; if (o.med_to_tx != TO + 1) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", o.med_to_tx, TO + 1); end
    checks++; if (o.n_tx != NCH) begin errors++; $display("FAIL timeout_ntx: got %0d expected %0d", o.n_tx, NCH); end
    checks++; if (o.tx_seq !== exp_seq()) begin errors++; $display("FAIL timeout_txseq: got %h expected %h", o.tx_seq, exp_seq()); end
    checks++; if (o.stab_bad != 0) begin errors++; $display("FAIL timeout_seltx_stable: got %0d expected 0", o.stab_bad); end
    k_sweep++;
    d = $urandom_range(1, TO - 1);
    run_position(d, $urandom_range(1, 4), -1, -1, o);
    checks++; if (o.erro !== 1'b0) begin errors++; $display("FAIL timeout_recover_erro: got %b expected 0", o.erro); end
    checks++; if (o.med_to_tx != d + 1) begin errors++; $display("FAIL timeout_recover_latency: got %0d expected %0d", o.med_to_tx, d + 1); end
    k_sweep++;
  endtask

  task automatic test_simultaneous();
    obs_t o;
    run_position(0, 1, -1, -1, o);
    checks++; if (o.erro !== 1'b1) begin errors++; $display("FAIL simul_pre_erro: got %b expected 1", o.erro); end
    k_sweep++;
    run_position(TO, 3, -1, -1, o);
    checks++; if (o.erro !== 1'b0) begin errors++; $display("FAIL simul_erro: got %b expected 0", o.erro); end
    checks++; if (o.med_to_tx != TO + 1) begin errors++; $display("FAIL simul_latency: got %0d expected %0d", o.med_to_tx, TO + 1); end
    k_sweep++;
  endtask

  task automatic test_random();
    obs_t o;
    int   d, ks;
    for (int i = 0; i < 10; i++) begin
      d  = $urandom_range(0, TO + 6);
      ks = $urandom_range(1, 5);
      run_position(d, ks, -1, -1, o);
      checks++; if (o.pos != tri_pos(k_sweep)) begin errors++; $display("FAIL rand_pos[%0d]: got %0d expected %0d", i, o.pos, tri_pos(k_sweep)); end
      checks++; if (o.erro !== exp_erro(d)) begin errors++; $display("FAIL rand_erro[%0d] d=%0d: got %b expected %b", i, d, o.erro, exp_erro(d)); end
      checks++; if (o.med_to_tx != exp_med_to_tx(d)) begin errors++; $display("FAIL rand_latency[%0d] d=%0d: got %0d expected %0d", i, d, o.med_to_tx, exp_med_to_tx(d)); end
      checks++; if (o.tx_seq !== exp_seq()) begin errors++; $display("FAIL rand_txseq[%0d]: got %h expected %h", i, o.tx_seq, exp_seq()); end
      checks++; if (o.total != exp_total(d, ks)) begin errors++; $display("FAIL rand_total[%0d]: got %0d expected %0d", i, o.total, exp_total(d, ks)); end
      checks++; if (o.n_fim != 1 || o.state_after != 1) begin errors++; $display("FAIL rand_end[%0d]: got fim=%0d st=%0d expected fim=1 st=1", i, o.n_fim, o.state_after); end
      k_sweep++;
    end
  endtask

  task automatic test_ligar_drop();
    obs_t o;
    logic ok;
    run_position($urandom_range(1, TO), $urandom_range(1, 4), 3, -1, o);
    checks++; if (o.state_after != 0) begin errors++; $display("FAIL drop_parks: got %0d expected 0", o.state_after); end
    checks++; if (o.n_tx != NCH) begin errors++; $display("FAIL drop_ntx: got %0d expected %0d", o.n_tx, NCH); end
    checks++; if (o.tx_seq !== exp_seq()) begin errors++; $display("FAIL drop_txseq: got %h expected %h", o.tx_seq, exp_seq()); end
    checks++; if (o.pos_after != tri_pos(k_sweep + 1)) begin errors++; $display("FAIL drop_pos_after: got %0d expected %0d", o.pos_after, tri_pos(k_sweep + 1)); end
    k_sweep++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (db_estado !== 4'd0 || sel_posicao !== 3'(tri_pos(k_sweep))) begin
        errors++;
        $display("FAIL drop_hold[%0d]: got st=%0d pos=%0d expected st=0 pos=%0d", i, db_estado, sel_posicao, tri_pos(k_sweep));
      end
    end
    ligar = 1'b1;
    wait_state(4'd1, 3, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drop_resume: got %b expected 1", ok); end
    run_position($urandom_range(1, TO), 2, -1, -1, o);
    checks++; if (o.pos != tri_pos(k_sweep)) begin errors++; $display("FAIL drop_resume_pos: got %0d expected %0d", o.pos, tri_pos(k_sweep)); end
    checks++; if (o.pos_after != tri_pos(k_sweep + 1)) begin errors++; $display("FAIL drop_resume_next: got %0d expected %0d", o.pos_after, tri_pos(k_sweep + 1)); end
    k_sweep++;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic ok;
    for (int i = 0; i < 14 && tri_pos(k_sweep) != 5; i++) begin
      run_position($urandom_range(1, TO), $urandom_range(1, 3), -1, -1, o);
      checks++; if (o.pos != tri_pos(k_sweep)) begin errors++; $display("FAIL rstmid_walk_pos: got %0d expected %0d", o.pos, tri_pos(k_sweep)); end
      k_sweep++;
    end
    run_position($urandom_range(1, TO), 2, -1, $urandom_range(0, NCH - 1), o);
    checks++; if (o.pos != 5) begin errors++; $display("FAIL rstmid_at_pos5: got %0d expected 5", o.pos); end
    checks++; if (o.rst_hit !== 1'b1) begin errors++; $display("FAIL rstmid_hit: got %b expected 1", o.rst_hit); end
    checks++; if (o.rst_tx !== 1'b0) begin errors++; $display("FAIL rstmid_tx: got %b expected 0", o.rst_tx); end
    checks++; if (o.rst_pos != 0) begin errors++; $display("FAIL rstmid_pos: got %0d expected 0", o.rst_pos); end
    checks++; if (o.rst_st != 0) begin errors++; $display("FAIL rstmid_state: got %0d expected 0", o.rst_st); end
    checks++; if (sel_rom !== 3'd0 || sel_transmissao !== 3'd0) begin errors++; $display("FAIL rstmid_sel: got rom=%0d tx=%0d expected 0/0", sel_rom, sel_transmissao); end
    @(negedge clock);
    ligar = 1'b1;
    reset = 1'b0;
    k_sweep = 0;
    wait_state(4'd1, 3, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_restart: got %b expected 1", ok); end
    for (int i = 0; i < 3; i++) begin
      run_position($urandom_range(1, TO), $urandom_range(1, 3), -1, -1, o);
      checks++; if (o.pos != tri_pos(k_sweep) || o.pos_after != tri_pos(k_sweep + 1)) begin
        errors++;
        $display("FAIL rstmid_sweep[%0d]: got %0d->%0d expected %0d->%0d", i, o.pos, o.pos_after, tri_pos(k_sweep), tri_pos(k_sweep + 1));
      end
      k_sweep++;
    end
  endtask

  initial begin
    reset = 1'b1; ligar = 1'b0; sensor_pronto = 1'b0; serial_pronto = 1'b0;
    test_reset();
    test_first_position();
    test_sweep();
    test_timeout();
    test_simultaneous();
    test_random();
    test_ligar_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
